// File: rtl/nibble_serial_subtractor.sv
// Serial subtractor: diff = a - b - bin, one nibble per clock, LS nibble first.
// Each nibble uses flat 4-bit borrow lookahead; the borrow is registered between nibbles.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic [CW+1:0]    w_base;
    logic [3:0]       w_an;
    logic [3:0]       w_bn;
    logic [3:0]       w_g;
    logic [3:0]       w_p;
    logic [4:0]       w_br;
    logic [3:0]       w_d;
    logic             w_last;

    assign w_base = {r_cnt, 2'b00};
    assign w_an   = r_a[w_base +: 4];
    assign w_bn   = r_b[w_base +: 4];
    assign w_g    = ~w_an & w_bn;
    assign w_p    = ~(w_an ^ w_bn);
    assign w_last = (r_cnt == CW'(NIB - 1));

    // Every borrow is a flat sum of products of g, p and the registered borrow.
    assign w_br[0] = r_borrow;
    assign w_br[1] = w_g[0] | (w_p[0] & r_borrow);
    assign w_br[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_borrow);
    assign w_br[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0] & r_borrow);
    assign w_br[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                   | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_borrow);
    assign w_d = w_an ^ w_bn ^ w_br[3:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_diff[w_base +: 4] <= w_d;
                    r_borrow            <= w_br[4];
                    r_cnt               <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_bout <= w_br[4];
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs come only from registers and state decode.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign diff      = r_diff;
    assign bout      = r_bout;
endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Sequential subtractor computing diff = a - b - bin on WIDTH-bit operands, 4 bits per clock.
- Each nibble is computed with 4-bit borrow-lookahead (generate/propagate) logic. The borrow is registered between nibbles.
- Counterpart to the team's 4-bit carry-look-ahead adder: the subtract direction, built to trade area for latency in the arithmetic datapath.
- Valid/ready handshake on input and output.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NIB (localparam), WIDTH/4, number of nibble steps per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, bin are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  diff and bout are valid
- out_ready  input  1  consumer accepts the result
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned)

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; nibble counter = 0; internal borrow = 0.
  - Operand and result registers cleared.
  - Outputs: in_ready=1, out_valid=0, diff=0, bout=0. All take effect immediately, without waiting for a clock edge.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready: capture a, b and bin into the internal borrow; set counter=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN (in_ready=0, out_valid=0), one nibble per cycle, LS nibble first:
  - an = a[4k+3:4k], bn = b[4k+3:4k], br0 = registered borrow.
  - Per bit i: g_i = ~an_i & bn_i; p_i = ~(an_i ^ bn_i).
  - br_{i+1} = g_i | (p_i & br_i), expanded as flat lookahead; no ripple chain.
  - d_i = an_i ^ bn_i ^ br_i.
  - Write d into diff nibble k; register br4 as the next borrow; k++.
  - After nibble NIB-1: bout = br4; go to DONE.
- DONE:
  - out_valid=1; diff and bout held stable.
  - When out_ready=1: go to IDLE. in_ready rises the following cycle.
  - No input is accepted in DONE; there is no back-to-back overlap.
- Latency:
  - Accept edge is T0. out_valid rises after edge T0+NIB (4 cycles for WIDTH=16).
  - Throughput is one operation per NIB+2 cycles minimum.
- Output holding:
  - diff and bout are only meaningful when out_valid=1.
  - They keep their last value after the DONE→IDLE transition until the next operation overwrites nibbles.
- Boundary conditions:
  - in_valid is ignored while in RUN or DONE. a, b and bin may change freely after acceptance, because operands are registered.
  - out_ready is ignored outside DONE. out_valid stays high indefinitely under backpressure.
  - in_valid asserted in the same cycle DONE exits is not accepted. It is accepted on the next IDLE cycle if it is still asserted.
  - rst_n asserted mid-RUN or in DONE aborts immediately to the reset values. No partial result is ever flagged valid.
  - Wrap-around: the result is always modulo 2^WIDTH. bout=1 exactly when the unsigned result underflowed.
  - bin=1 with a=b gives diff = all-ones, bout=1.
- No combinational path exists from any input to any output. All outputs are driven from registers or state decode.

Test Plan (WIDTH=16):
- Basic: a=0x1234, b=0x0234, bin=0 → diff=0x1000, bout=0. out_valid rises exactly 4 cycles after the accept edge.
- Cross-nibble borrow: a=0x0100, b=0x0001, bin=0 → diff=0x00FF, bout=0. Then a=0x8000, b=0x7FFF, bin=1 → diff=0x0000, bout=0.
- Underflow: a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1. Then a=b=0x5A5A, bin=1 → diff=0xFFFF, bout=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - Required: out_valid and diff stay stable, in_ready=0, and a new in_valid is ignored.
  - After out_ready=1 for one cycle: in_ready=1 on the next cycle.
- Reset mid-operation: pulse rst_n=0 asynchronously (between edges) two cycles after accepting a=0xFFFF, b=0x0001.
  - Required: out_valid=0, diff=0, bout=0, in_ready=1 immediately.
  - Next operation a=0x0003, b=0x0001 → diff=0x0002, bout=0.
- Random: 200 random a, b, bin with random out_ready stalls.
  - Required: each result equals the model ({1'b0,a} - b - bin), with diff = low 16 bits and bout = bit 16.
  - Required: no result is lost or duplicated.
